// File: rtl/prog_fetch.sv
// Instruction fetch sequencer: drives the program store address/load strobe,
// resolves jump and halt opcodes, and forwards other words through a 1-entry valid/ready register.
module prog_fetch #(
  parameter int          ADDR_W  = 4,
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  JMP_OP  = 4'hA,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter int          MAX_JMP = 16
) (
  input  logic              c,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] start_a,
  output logic [ADDR_W-1:0] a,
  output logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] ir,
  output logic              ir_v,
  input  logic              ir_rdy,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_JMP + 1);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] jmp_cnt, jmp_inc;
  logic [3:0]       op;
  logic             cap, is_halt, is_jmp, fwd, start, runaway;

  assign op      = d[DATA_W-1 -: 4];
  assign cap     = ld;
  assign is_halt = cap && (op == HALT_OP);
  assign is_jmp  = cap && (op == JMP_OP) && !is_halt;
  assign fwd     = cap && !is_halt && !is_jmp;
  assign jmp_inc = jmp_cnt + 1'b1;
  // The counter stops exactly at MAX_JMP because that jump also forces HALT.
  assign runaway = is_jmp && (jmp_inc == CNT_W'(MAX_JMP));
  assign start   = (state != FETCH) && run;
  assign a       = pc;

  always_ff @(posedge c) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT: if (run) state_nx = FETCH;
      FETCH:      if (is_halt || runaway) state_nx = HALT;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    halted = 1'b0;
    case (state)
      FETCH:   ld = !ir_v || ir_rdy;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      pc      <= '0;
      jmp_cnt <= '0;
      ir      <= '0;
      ir_v    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (start) begin
        pc      <= start_a;
        jmp_cnt <= '0;
        err     <= 1'b0;
      end else if (is_jmp) begin
        pc      <= d[ADDR_W-1:0];
        jmp_cnt <= jmp_inc;
        if (runaway) err <= 1'b1;
      end else if (fwd) begin
        pc      <= pc + 1'b1;
        jmp_cnt <= '0;
      end

      // A same-edge capture replaces the accepted word with no bubble.
      if (fwd) begin
        ir   <= d;
        ir_v <= 1'b1;
      end else if (ir_v && ir_rdy) begin
        ir_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_fetch.sv
// Bench for prog_fetch: directed vector table and corner sequences, then random
// stimulus, all cross-checked every cycle against a behavioural model.
module tb_prog_fetch;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          c = 1'b0;
  logic          rst = 1'b1, run = 1'b0, ir_rdy = 1'b0;
  logic [AW-1:0] start_a = '0, a, pc;
  logic          ld, ir_v, halted, err;
  logic [DW-1:0] d, ir;
  logic [DW-1:0] mem [16];

  int total = 0;
  int bad   = 0;

  // model state
  bit            m_fetching = 0, m_stopped = 0, m_err = 0, m_irv = 0;
  int            m_pc = 0, m_jumps = 0;
  logic [DW-1:0] m_ir = '0;

  always #5 c = ~c;
  assign d = mem[a];

  prog_fetch #(.ADDR_W(AW), .DATA_W(DW), .JMP_OP(4'hA), .HALT_OP(4'hF), .MAX_JMP(16)) dut (
    .c(c), .rst(rst), .run(run), .start_a(start_a), .a(a), .ld(ld), .d(d),
    .ir(ir), .ir_v(ir_v), .ir_rdy(ir_rdy), .pc(pc), .halted(halted), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit rn, input int sa, input bit rdy);
    logic [DW-1:0] w;
    bit take;
    if (r) begin
      m_fetching = 0; m_stopped = 0; m_err = 0; m_irv = 0;
      m_pc = 0; m_jumps = 0; m_ir = '0;
      return;
    end
    w    = mem[m_pc];
    take = m_fetching && (!m_irv || rdy);
    if (m_irv && rdy) m_irv = 0;
    if (take) begin
      if (w[31:28] == 4'hF) begin
        m_fetching = 0; m_stopped = 1;
      end else if (w[31:28] == 4'hA) begin
        m_pc = int'(w[3:0]);
        m_jumps++;
        if (m_jumps == 16) begin m_err = 1; m_fetching = 0; m_stopped = 1; end
      end else begin
        m_ir = w; m_irv = 1; m_pc = (m_pc + 1) % 16; m_jumps = 0;
      end
    end else if (!m_fetching && rn) begin
      m_pc = sa; m_jumps = 0; m_err = 0; m_stopped = 0; m_fetching = 1;
    end
  endtask

  task automatic tick(input bit r, input bit rn, input logic [AW-1:0] sa, input bit rdy);
    rst = r; run = rn; start_a = sa; ir_rdy = rdy;
    @(posedge c);
    model_edge(r, rn, int'(sa), rdy);
    #1;
    chk("m_ir",     ir,     m_ir);
    chk("m_ir_v",   ir_v,   m_irv);
    chk("m_pc",     pc,     m_pc);
    chk("m_a",      a,      m_pc);
    chk("m_halted", halted, m_stopped);
    chk("m_err",    err,    m_err);
    chk("m_ld",     ld,     m_fetching && (!m_irv || ir_rdy));
  endtask

  typedef struct {
    bit            rst, run, rdy;
    logic [AW-1:0] sa;
    bit            e_irv, e_ld;
    logic [DW-1:0] e_ir;
    logic [AW-1:0] e_pc;
  } vec_t;

  task automatic fill_linear();
    for (int unsigned i = 0; i < 16; i++) mem[i] = DW'(i + 1);
  endtask

  initial begin
    vec_t vt [20];
    logic [DW-1:0] w;

    fill_linear();
    vt[0] = '{rst:0, run:1, rdy:1, sa:0, e_irv:0, e_ld:1, e_ir:0, e_pc:0};
    for (int k = 1; k < 20; k++)
      vt[k] = '{rst:0, run:0, rdy:1, sa:0, e_irv:1, e_ld:1,
                e_ir:DW'(((k - 1) % 16) + 1), e_pc:AW'(k % 16)};

    // reset with run and ir_rdy high
    tick(1, 1, 4'd7, 1);
    tick(1, 1, 4'd7, 1);
    chk("rst_a", a, 0); chk("rst_ld", ld, 0); chk("rst_irv", ir_v, 0);
    chk("rst_halted", halted, 0); chk("rst_err", err, 0); chk("rst_ir", ir, 0);

    // linear fetch with wrap
    for (int k = 0; k < 20; k++) begin
      tick(vt[k].rst, vt[k].run, vt[k].sa, vt[k].rdy);
      chk($sformatf("lin%0d_irv", k), ir_v, vt[k].e_irv);
      chk($sformatf("lin%0d_pc", k), pc, vt[k].e_pc);
      chk($sformatf("lin%0d_ld", k), ld, vt[k].e_ld);
      if (vt[k].e_irv) chk($sformatf("lin%0d_ir", k), ir, vt[k].e_ir);
    end

    // jump: 1,2,3, bubble, 9,10
    mem[3] = 32'hA000_0008;
    tick(1, 0, 0, 1); tick(0, 1, 0, 1);
    tick(0, 0, 0, 1); chk("jmp_ir1", ir, 1);
    tick(0, 0, 0, 1); chk("jmp_ir2", ir, 2);
    tick(0, 0, 0, 1); chk("jmp_ir3", ir, 3); chk("jmp_pc3", pc, 3);
    tick(0, 0, 0, 1); chk("jmp_bubble", ir_v, 0); chk("jmp_pc8", pc, 8);
    tick(0, 0, 0, 1); chk("jmp_ir9", ir, 9); chk("jmp_irv9", ir_v, 1);
    tick(0, 0, 0, 1); chk("jmp_ir10", ir, 10);
    mem[3] = 32'd4;

    // backpressure while ir=5
    tick(1, 0, 0, 1); tick(0, 1, 0, 1);
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 1);
    chk("bp_ir5", ir, 5);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 0);
      chk("bp_hold_ir", ir, 5); chk("bp_hold_irv", ir_v, 1);
      chk("bp_hold_pc", pc, 5); chk("bp_hold_ld", ld, 0);
    end
    tick(0, 0, 0, 1); chk("bp_ir6", ir, 6);
    tick(0, 0, 0, 1); chk("bp_ir7", ir, 7);

    // halt, drain, restart
    mem[5] = 32'hF000_0000;
    tick(1, 0, 0, 1); tick(0, 1, 0, 1);
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 1);
    chk("halt_ir5", ir, 5); chk("halt_pc5", pc, 5);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("halt_pend_irv", ir_v, 1); chk("halt_pend_ir", ir, 5); chk("halt_pend_h", halted, 0);
    tick(0, 0, 0, 1);
    chk("halt_h", halted, 1); chk("halt_pc", pc, 5); chk("halt_ld", ld, 0);
    chk("halt_irv", ir_v, 0); chk("halt_irhold", ir, 5);
    tick(0, 0, 0, 1); chk("halt_stays", halted, 1); chk("halt_pc_stays", pc, 5);
    tick(0, 1, 0, 1); chk("rs_h", halted, 0); chk("rs_pc", pc, 0);
    tick(0, 0, 0, 1); chk("rs_ir1", ir, 1); chk("rs_irv", ir_v, 1);
    mem[5] = 32'd6;

    // runaway jump loop
    mem[2] = 32'hA000_0002;
    tick(1, 0, 0, 1); tick(0, 1, 0, 1);
    tick(0, 0, 0, 1); tick(0, 0, 0, 1); chk("run_ir2", ir, 2);
    for (int k = 0; k < 15; k++) tick(0, 0, 0, 1);
    chk("run_err15", err, 0); chk("run_h15", halted, 0); chk("run_irv15", ir_v, 0);
    tick(0, 0, 0, 1);
    chk("run_err16", err, 1); chk("run_h16", halted, 1); chk("run_pc16", pc, 2); chk("run_ld16", ld, 0);
    tick(0, 1, 4'd9, 1); chk("run_restart_err", err, 0); chk("run_restart_pc", pc, 9);
    mem[2] = 32'd3;

    // reset mid-stream discards pending ir
    tick(1, 0, 0, 1); tick(0, 1, 0, 1);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 1);
    tick(0, 0, 0, 0); chk("mid_pre_irv", ir_v, 1);
    tick(1, 0, 0, 0);
    chk("mid_a", a, 0); chk("mid_ir", ir, 0); chk("mid_irv", ir_v, 0);
    chk("mid_ld", ld, 0); chk("mid_h", halted, 0); chk("mid_err", err, 0);

    // random programs and handshakes against the model
    for (int p = 0; p < 6; p++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        w = $urandom;
        case ($urandom_range(0, 19))
          0:          w[31:28] = 4'hF;
          1, 2, 3, 4: w[31:28] = 4'hA;
          default:    if (w[31:28] == 4'hA || w[31:28] == 4'hF) w[31:28] = 4'h1;
        endcase
        mem[i] = w;
      end
      if (p == 5) mem[0] = 32'hA000_0000;
      tick(1, 0, 0, 0);
      for (int k = 0; k < 150; k++)
        tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0),
             AW'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
